spike_event_logger: RTL
=======================

# spike_event_logger

Timestamped spike-event logger sitting directly downstream of the two-neuron Hodgkin-Huxley/STDP pair. It consumes the presynaptic and postsynaptic spike levels, detects rising edges, and stamps each event with a free-running cycle counter. Events are buffered in a small FIFO and streamed out as byte frames over a valid/ready handshake, so spike timing (and the STDP pre/post ordering) can be read off-chip without losing same-cycle coincidences.

## Interface
Parameters:
- TS_WIDTH, 14, timestamp counter width; frame carries {src[1:0], ts[13:0]}; fixed at 14 for the 2-byte header.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- spike_a  in  1  presynaptic spike level (neuron 1).
- spike_b  in  1  postsynaptic spike level (neuron 2).
- vmem_a  in  8  neuron 1 membrane byte; used only with SPIKE_LOG_VMEM_EN.
- clr_ovf  in  1  clears the sticky overflow flag.
- evt_byte  out  8  output frame byte.
- evt_valid  out  1  evt_byte holds a valid byte.
- evt_ready  in  1  consumer accepts the byte this cycle.
- overflow  out  1  sticky: at least one event dropped.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Timestamp: ts counter increments every cycle; wraps from 2^14-1 to 0 with no flag.
- Edge detect: spike_x_d registers spike_x each cycle; event on spike_x & ~spike_x_d. Reset value of spike_x_d is 1, so a level already high when rst deasserts produces no event.
- Source code: src = {edge_b, edge_a}; 01 = pre only, 10 = post only, 11 = both in the same cycle (one entry, not two). 00 never written.
- Entry = {src, ts} (16 bits), ts = counter value in the detecting cycle.
- FIFO: write on any edge; when full and no pop in the same cycle, the event is dropped and overflow sets. Full plus pop in the same cycle accepts the write.
- overflow: set on drop, cleared by clr_ovf; a drop and clr_ovf in the same cycle leave it set.
- Serializer FSM: IDLE -> HDR -> LSB -> IDLE (-> VM before IDLE when the macro is on).
  - IDLE: if FIFO is non-empty, pop into a frame register and go to HDR.
  - HDR: evt_byte = {src, ts[13:8]}.
  - LSB: evt_byte = ts[7:0].
  - A state advances only on evt_valid & evt_ready.
  - From the last byte, if the FIFO is non-empty, pop and go directly to HDR (back-to-back frames, no idle cycle).
- Handshake: evt_valid is high in all states except IDLE. evt_byte is stable while evt_valid & ~evt_ready. evt_valid never drops without acceptance.
- level counts FIFO entries only, excluding the frame held in the serializer.

## Timing
- Reset (cycle after rst sampled high):
  - evt_valid = 0, evt_byte = 0, overflow = 0, level = 0.
  - ts = 0, FSM = IDLE, FIFO empty.
- Reset mid-frame: the frame is abandoned and FIFO contents discarded; no partial-frame completion.
- Latency: edge in cycle c -> FIFO write at the end of c -> pop at the end of c+1 -> evt_valid = 1 with header in c+2.
- With evt_ready tied high, one 2-byte frame per 2 cycles. Sustained throughput is 1 event per 2 cycles; bursts are absorbed by DEPTH.
- level updates the cycle after the write/pop edge. Simultaneous push and pop leave level unchanged.

## Configuration
- SPIKE_LOG_VMEM_EN defined:
  - Entry widens to 24 bits, adding vmem_a sampled in the detecting cycle.
  - Frame is 3 bytes: HDR, LSB, VM (evt_byte = vmem_a snapshot).
  - Back-to-back rate is 1 frame per 3 cycles.
- Undefined: vmem_a is ignored (tied off internally), frames are 2 bytes, and the VM state does not exist.

## Test plan
- Reset then single pre spike: spike_a rises in cycle 10 (ts=10 after reset), evt_ready=1.
  - Cycle 12: evt_byte = 0x40, evt_valid = 1.
  - Cycle 13: evt_byte = 0x0A.
  - Cycle 14: evt_valid = 0.
- Coincidence: spike_a and spike_b rise together at ts=0x1234 -> one frame, bytes 0xD2, 0x34; level peaks at 1.
- Backpressure: evt_ready=0 for 20 cycles with header pending -> evt_byte constant and evt_valid held. Then ready=1 -> exactly 2 bytes per frame, no duplicates.
- Overflow: evt_ready=0 and 10 isolated pre edges with DEPTH=8.
  - One frame held in the serializer, level = 8, overflow = 1, one event dropped.
  - clr_ovf pulse -> overflow = 0.
- Wrap and reset: an edge at ts=0x3FFF gives bytes 0x7F, 0xFF, and the next edge one cycle later gives ts=0x0000. Asserting rst during the LSB byte -> evt_valid = 0 next cycle and level = 0.
- With SPIKE_LOG_VMEM_EN: vmem_a = 0xA5 in the detecting cycle -> third byte 0xA5 after the header and LSB; back-to-back frames spaced 3 cycles apart.

Source files
------------

// File: rtl/spike_log_if.sv
// Byte-stream handshake carrying timestamped spike frames out of the logger.
interface spike_log_if;
  logic [7:0] evt_byte;
  logic       evt_valid;
  logic       evt_ready;

  modport master (output evt_byte, output evt_valid, input evt_ready);
  modport slave  (input evt_byte, input evt_valid, output evt_ready);
endinterface

// File: rtl/spike_event_logger.sv
// Timestamped spike-edge logger: edge detect, FIFO buffering and byte-frame serializer.
// Optional membrane-byte capture (third frame byte) enabled by defining SPIKE_LOG_VMEM_EN.
module spike_event_logger #(
  parameter int TS_WIDTH = 14,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_a,
  input  logic                   spike_b,
  input  logic [7:0]             vmem_a,
  input  logic                   clr_ovf,
  spike_log_if.master            evt,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
`ifdef SPIKE_LOG_VMEM_EN
  localparam int ENTRY_W = TS_WIDTH + 2 + 8;
  typedef enum logic [1:0] {IDLE, HDR, LSB, VM} state_t;
`else
  localparam int ENTRY_W = TS_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, HDR, LSB} state_t;
`endif

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                spike_a_q, spike_a_d, spike_b_q, spike_b_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  entry_d, frame_q, frame_d;
  state_t              state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                edge_a, edge_b, push_req, push, pop, drop;
  logic                fifo_empty, fifo_full, accept, last_byte;

`ifndef SPIKE_LOG_VMEM_EN
  logic unused_vmem;
  assign unused_vmem = ^vmem_a;
`endif

  always_comb begin
    spike_a_d  = spike_a;
    spike_b_d  = spike_b;
    edge_a     = spike_a & ~spike_a_q;
    edge_b     = spike_b & ~spike_b_q;
    push_req   = edge_a | edge_b;
    ts_d       = ts_q + TS_WIDTH'(1);
`ifdef SPIKE_LOG_VMEM_EN
    entry_d    = {vmem_a, edge_b, edge_a, ts_q};
    last_byte  = (state_q == VM);
`else
    entry_d    = {edge_b, edge_a, ts_q};
    last_byte  = (state_q == LSB);
`endif
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(DEPTH));
    accept     = valid_q & evt.evt_ready;
    // A pop into the frame register happens from IDLE or as the last byte is taken.
    pop        = ~fifo_empty & ((state_q == IDLE) | (last_byte & accept));
    push       = push_req & (~fifo_full | pop);
    drop       = push_req & fifo_full & ~pop;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    ovf_d      = drop | (ovf_q & ~clr_ovf);
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    case (state_q)
      HDR:     if (accept) state_d = LSB;
`ifdef SPIKE_LOG_VMEM_EN
      LSB:     if (accept) state_d = VM;
      VM:      if (accept) state_d = IDLE;
`else
      LSB:     if (accept) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    if (pop) begin
      frame_d = mem_q[rd_ptr_q];
      state_d = HDR;
    end
    // Output byte is registered from the state being entered.
    case (state_d)
      HDR:     byte_d = {frame_d[TS_WIDTH+1:TS_WIDTH], frame_d[TS_WIDTH-1:8]};
      LSB:     byte_d = frame_d[7:0];
`ifdef SPIKE_LOG_VMEM_EN
      VM:      byte_d = frame_d[ENTRY_W-1 -: 8];
`endif
      default: byte_d = 8'h00;
    endcase
    valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q      <= '0;
      spike_a_q <= 1'b1;
      spike_b_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      frame_q   <= '0;
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      spike_a_q <= spike_a_d;
      spike_b_q <= spike_b_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign evt.evt_byte  = byte_q;
  assign evt.evt_valid = valid_q;
  assign overflow      = ovf_q;
  assign level         = count_q;

endmodule
